// File: rtl/video_pkg.sv
// Shared constants, types and address helpers for the indexed-colour frame buffer.
package video_pkg;

  localparam int FB_WIDTH    = 400;
  localparam int FB_HEIGHT   = 300;
  localparam int INDEX_BITS  = 4;
  localparam int RED_BITS    = 4;
  localparam int GREEN_BITS  = 4;
  localparam int BLUE_BITS   = 4;
  localparam int COLOR_BITS  = RED_BITS + GREEN_BITS + BLUE_BITS;
  localparam int PAL_DEPTH   = 2 ** INDEX_BITS;
  localparam int X_BITS      = $clog2(FB_WIDTH);
  localparam int Y_BITS      = $clog2(FB_HEIGHT);
  localparam int FB_PIXELS   = FB_WIDTH * FB_HEIGHT;
  localparam int RAM_DEPTH   = 2 * FB_PIXELS;
  localparam int ADDR_BITS   = $clog2(RAM_DEPTH);

  typedef logic [COLOR_BITS-1:0] color_t;
  typedef logic [INDEX_BITS-1:0] pal_index_t;
  typedef logic [X_BITS-1:0]     x_t;
  typedef logic [Y_BITS-1:0]     y_t;
  typedef logic [ADDR_BITS-1:0]  fb_addr_t;

  localparam x_t X_LIMIT = x_t'(FB_WIDTH);
  localparam y_t Y_LIMIT = y_t'(FB_HEIGHT);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } swap_state_t;

  // Every operand is widened to the full RAM address before the add.
  function automatic fb_addr_t fb_addr(logic buf_sel, x_t x, y_t y);
    fb_addr_t base;
    base = buf_sel ? fb_addr_t'(FB_PIXELS) : '0;
    return base + fb_addr_t'(y) * fb_addr_t'(FB_WIDTH) + fb_addr_t'(x);
  endfunction

  // Grey ramp: the index is truncated or zero-extended into each channel.
  function automatic color_t grey_entry(pal_index_t idx);
    logic [RED_BITS-1:0]   r;
    logic [GREEN_BITS-1:0] g;
    logic [BLUE_BITS-1:0]  b;
    r = RED_BITS'(idx);
    g = GREEN_BITS'(idx);
    b = BLUE_BITS'(idx);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port pixel RAM: one write port, one registered read port (BRAM style).
module frame_ram #(
  parameter int DEPTH     = 240000,
  parameter int ADDR_BITS = 18,
  parameter int DATA_BITS = 4
) (
  input  logic                 clk_i,
  input  logic                 wr_en_i,
  input  logic [ADDR_BITS-1:0] wr_addr_i,
  input  logic [DATA_BITS-1:0] wr_data_i,
  input  logic [ADDR_BITS-1:0] rd_addr_i,
  output logic [DATA_BITS-1:0] rd_data_o
);

  logic [DATA_BITS-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset branch; a reset loop over a memory turns it into
  // flops and prevents block-RAM inference, and the pixel contents need no defined value.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/frame_buffer_palette.sv
// Double-buffered indexed-colour frame buffer with palette lookup; buffer swaps
// complete on the vsync leading edge so the displayed frame never tears.
module frame_buffer_palette
  import video_pkg::*;
#(
  parameter bit VSYNC_ACTIVE_HIGH = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [X_BITS-1:0]     rd_x_i,
  input  logic [Y_BITS-1:0]     rd_y_i,
  output logic [COLOR_BITS-1:0] color_o,
  input  logic                  vga_vs_i,
  input  logic                  wr_en_i,
  input  logic [X_BITS-1:0]     wr_x_i,
  input  logic [Y_BITS-1:0]     wr_y_i,
  input  logic [INDEX_BITS-1:0] wr_index_i,
  input  logic                  pal_wr_en_i,
  input  logic [INDEX_BITS-1:0] pal_wr_addr_i,
  input  logic [COLOR_BITS-1:0] pal_wr_color_i,
  input  logic                  swap_req_i,
  output logic                  swap_busy_o,
  output logic                  swap_ack_o,
  output logic                  front_sel_o
);

  localparam logic VS_ACTIVE = VSYNC_ACTIVE_HIGH;

  swap_state_t state_q, state_d;
  logic        swap_done;
  logic        front_sel_q;
  logic        swap_ack_q;
  logic        vs_q;
  logic        vs_edge;

  assign vs_edge = (vga_vs_i == VS_ACTIVE) && (vs_q != VS_ACTIVE);

  always_comb begin
    // NOTE: every output of this block is given a default before the case, so no
    // path leaves a value unassigned and no latch is inferred.
    state_d   = state_q;
    swap_done = 1'b0;
    case (state_q)
      IDLE:    if (swap_req_i) state_d = PENDING;
      PENDING: if (vs_edge) begin
        state_d   = IDLE;
        swap_done = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments make every register here sample pre-edge values,
  // which is also why a pixel write in the swap cycle still lands in the old back buffer.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      front_sel_q <= 1'b0;
      swap_ack_q  <= 1'b0;
      vs_q        <= ~VS_ACTIVE;
    end else begin
      state_q    <= state_d;
      swap_ack_q <= swap_done;
      vs_q       <= vga_vs_i;
      if (swap_done) begin
        front_sel_q <= ~front_sel_q;
      end
    end
  end

  assign swap_busy_o = (state_q == PENDING);
  assign swap_ack_o  = swap_ack_q;
  assign front_sel_o = front_sel_q;

  // Rasteriser always writes the buffer that is not on screen.
  logic       wr_in_range;
  logic       ram_wr_en;
  fb_addr_t   wr_addr;
  logic       rd_in_range;
  logic       rd_in_range_q;
  fb_addr_t   rd_addr;
  pal_index_t ram_rd_index;

  assign wr_in_range = (wr_x_i < X_LIMIT) && (wr_y_i < Y_LIMIT);
  assign ram_wr_en   = wr_en_i && wr_in_range;
  assign wr_addr     = fb_addr(~front_sel_q, wr_x_i, wr_y_i);

  assign rd_in_range = (rd_x_i < X_LIMIT) && (rd_y_i < Y_LIMIT);
  assign rd_addr     = rd_in_range ? fb_addr(front_sel_q, rd_x_i, rd_y_i) : '0;

  frame_ram #(
    .DEPTH     (RAM_DEPTH),
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (INDEX_BITS)
  ) u_frame_ram (
    .clk_i     (clk_i),
    .wr_en_i   (ram_wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_index_i),
    .rd_addr_i (rd_addr),
    .rd_data_o (ram_rd_index)
  );

  color_t palette_q [PAL_DEPTH];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < PAL_DEPTH; i++) begin
        palette_q[i] <= grey_entry(pal_index_t'(i));
      end
    end else if (pal_wr_en_i) begin
      palette_q[pal_wr_addr_i] <= pal_wr_color_i;
    end
  end

  // Second pipeline stage: palette lookup; out-of-range reads show entry 0.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_in_range_q <= 1'b0;
      color_o       <= '0;
    end else begin
      rd_in_range_q <= rd_in_range;
      color_o       <= rd_in_range_q ? palette_q[ram_rd_index] : palette_q[0];
    end
  end

endmodule
